// File: rtl/ao22_grant_scheduler.sv
// ---------------------------------------------------------------------------
// ao22_grant_scheduler
//
// Two-requester round-robin grant scheduler for the shared AND-AND-OR lane of
// the p-bit fabric. It owns the B-side select lines of an AO22 structure
// (y = d0&b1 | d1&b2), so only one requester's data bit reaches the lane at a
// time.
//
// Behaviour:
//   - Grants are one-hot and registered. b1 and b2 are never high together.
//   - At least one idle cycle separates any two grants (break-before-make).
//   - A hold limit force-releases a grant after HOLD_MAX cycles, so one
//     requester cannot starve the other.
//
// Parameters:
//   HOLD_W    width of the hold counter
//   HOLD_MAX  maximum grant length in cycles, 1 .. 2**HOLD_W-1
//
// Ports:
//   clk      in   system clock; all state changes on the rising edge
//   rst_n    in   synchronous active-low reset
//   en       in   allows new grants; never preempts an active grant
//   req[1:0] in   level requests, held until served or abandoned
//   done[1:0] in  release strobes; only the current owner's bit is honoured
//   d[1:0]   in   data bits (d[0] pairs with b1, d[1] pairs with b2)
//   b1       out  registered grant to requester 0
//   b2       out  registered grant to requester 1
//   busy     out  high while any grant is active
//   owner    out  index of the current or most recent owner
//   timeout  out  one-cycle pulse in the first idle cycle after a forced
//                 release
//   y        out  AO22 lane output, combinational from d and the grants
// ---------------------------------------------------------------------------
module ao22_grant_scheduler #(
    parameter int HOLD_W   = 4,
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    input  logic [1:0] done,
    input  logic [1:0] d,
    output logic       b1,
    output logic       b2,
    output logic       busy,
    output logic       owner,
    output logic       timeout,
    output logic       y
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // Counter value seen during the last allowed cycle of a grant.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

    state_t            state_q,    state_d;
    logic              ptr_q,      ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              owner_q,    owner_d;
    logic              timeout_q,  timeout_d;
    logic              b1_q,       b1_d;
    logic              b2_q,       b2_d;

    logic cur;
    logic rel_done;
    logic rel_drop;
    logic rel_limit;
    logic release_now;
    logic pick;

    always_comb begin
        // Index of the requester holding the lane. Only meaningful in a GNT
        // state.
        cur         = (state_q == GNT1);
        rel_done    = done[cur];
        rel_drop    = !req[cur];
        rel_limit   = (hold_cnt_q == HOLD_LAST);
        release_now = (state_q != IDLE) && (rel_done || rel_drop || rel_limit);

        // When both requesters are asking, the round-robin pointer decides.
        // When only one is asking, that one wins whatever the pointer says.
        pick = (req == 2'b11) ? ptr_q : req[1];

        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        owner_d    = owner_q;
        timeout_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && (req != 2'b00)) begin
                    state_d    = pick ? GNT1 : GNT0;
                    hold_cnt_d = '0;
                    owner_d    = pick;
                end
            end
            GNT0, GNT1: begin
                if (release_now) begin
                    state_d   = IDLE;
                    ptr_d     = ~cur;
                    // A timeout is reported only when the hold limit is the
                    // sole reason for the release.
                    timeout_d = rel_limit && !rel_done && !rel_drop;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The grant flops mirror the next state, so the select lines come
        // straight from registers with no decode after the clock edge.
        b1_d = (state_d == GNT0);
        b2_d = (state_d == GNT1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            hold_cnt_q <= '0;
            owner_q    <= 1'b0;
            timeout_q  <= 1'b0;
            b1_q       <= 1'b0;
            b2_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            owner_q    <= owner_d;
            timeout_q  <= timeout_d;
            b1_q       <= b1_d;
            b2_q       <= b2_d;
        end
    end

    assign b1      = b1_q;
    assign b2      = b2_q;
    assign busy    = b1_q | b2_q;
    assign owner   = owner_q;
    assign timeout = timeout_q;

    // The AO22 lane has no register, so y changes in the same cycle as d.
    assign y = (d[0] & b1_q) | (d[1] & b2_q);

endmodule

// File: tb/tb_ao22_grant_scheduler.sv
module tb_ao22_grant_scheduler;

    localparam int HOLD_W   = 4;
    localparam int HOLD_MAX = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] req;
    logic [1:0] done;
    logic [1:0] d;
    logic       b1, b2, busy, owner, timeout, y;

    int checks = 0;
    int errors = 0;

    ao22_grant_scheduler #(.HOLD_W(HOLD_W), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done), .d(d),
        .b1(b1), .b2(b2), .busy(busy), .owner(owner), .timeout(timeout), .y(y)
    );

    always #5 clk = ~clk;

    // Reference model. m_own is -1 when no grant is active, otherwise it is
    // the index of the owner. m_len counts the cycles of the current grant.
    int m_own   = -1;
    int m_len   = 0;
    int m_pref  = 0;
    int m_owner = 0;
    bit m_to    = 1'b0;
    bit started = 1'b0;

    always @(posedge clk) begin
        started = 1'b1;
        if (!rst_n) begin
            m_own = -1; m_len = 0; m_pref = 0; m_owner = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_own < 0) begin
                if (en && req != 2'b00) begin
                    if (req == 2'b11) m_own = m_pref;
                    else              m_own = req[1] ? 1 : 0;
                    m_len   = 1;
                    m_owner = m_own;
                end
            end else begin
                if (done[m_own] || !req[m_own] || m_len == HOLD_MAX) begin
                    m_to   = (m_len == HOLD_MAX) && !done[m_own] && req[m_own];
                    m_pref = 1 - m_own;
                    m_own  = -1;
                end else begin
                    m_len++;
                end
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, compare all outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            logic eb1, eb2;
            eb1 = (m_own == 0);
            eb2 = (m_own == 1);
            check("b1", b1, eb1);
            check("b2", b2, eb2);
            check("busy", busy, eb1 | eb2);
            check("owner", owner, m_owner[0]);
            check("timeout", timeout, m_to);
            check("y", y, (d[0] & eb1) | (d[1] & eb2));
            check("onehot", b1 & b2, 1'b0);
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        int g_own [4];
        int g_len [4];

        rst_n = 1'b0; en = 1'b0; req = 2'b00; done = 2'b00; d = 2'b00;
        nxt(); nxt();
        check("rst_b1", b1, 1'b0);
        check("rst_owner", owner, 1'b0);
        rst_n = 1'b1;

        // Reset in the middle of a grant to requester 1.
        en = 1'b1; req = 2'b10;
        nxt();
        check("pre_rst_b2", b2, 1'b1);
        rst_n = 1'b0; req = 2'b11;
        nxt();
        check("midrst_b1", b1, 1'b0);
        check("midrst_b2", b2, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_owner", owner, 1'b0);
        check("midrst_timeout", timeout, 1'b0);
        rst_n = 1'b1;
        nxt();
        check("post_rst_ptr0", b1, 1'b1);
        done = 2'b01;
        nxt();
        check("post_rst_release", b1, 1'b0);
        done = 2'b00; req = 2'b00;
        nxt();

        // Contention rotation: done pulsed on each grant's third cycle.
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            cnt = 0;
            while (!busy && cnt < 5) begin nxt(); cnt++; end
            check_int("rot_idle_gap", cnt, 1);
            g_own[g] = b2 ? 1 : 0;
            g_len[g] = 1;
            nxt(); if (busy) g_len[g]++;
            nxt(); if (busy) g_len[g]++;
            done = (g_own[g] == 1) ? 2'b10 : 2'b01;
            nxt();
            done = 2'b00;
            check("rot_released", busy, 1'b0);
            check_int("rot_len", g_len[g], 3);
            if (g > 0) check("rot_alternate", g_own[g] != g_own[g-1], 1'b1);
        end
        req = 2'b00;
        nxt();

        // Hold limit: requester 0 holds its request with no done.
        req = 2'b01;
        nxt();
        cnt = b1 ? 1 : 0;
        while (b1 && cnt < 20) begin nxt(); if (b1) cnt++; end
        check_int("timeout_len", cnt, 15);
        check("timeout_pulse", timeout, 1'b1);
        nxt();
        check("timeout_regrant", b1, 1'b1);
        check("timeout_one_cycle", timeout, 1'b0);

        // done arriving on the last allowed cycle: no timeout is reported.
        for (int i = 0; i < 14; i++) nxt();
        check("limit_cycle15_b1", b1, 1'b1);
        done = 2'b01;
        nxt();
        check("done_limit_b1", b1, 1'b0);
        check("done_limit_timeout", timeout, 1'b0);
        done = 2'b00; req = 2'b00;
        nxt();

        // en gating: no new grants while en is low, no preemption either.
        en = 1'b0; req = 2'b10;
        for (int i = 0; i < 3; i++) begin nxt(); check("en_off_b2", b2, 1'b0); end
        en = 1'b1;
        nxt();
        check("en_on_b2", b2, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin nxt(); check("en_drop_held", b2, 1'b1); end
        done = 2'b10;
        nxt();
        check("en_drop_release", b2, 1'b0);
        done = 2'b00; req = 2'b00; en = 1'b1;
        nxt();

        // AO22 datapath.
        req = 2'b01;
        nxt();
        d = 2'b10; #1;
        check("y_gnt0_d10", y, 1'b0);
        d = 2'b01; #1;
        check("y_gnt0_d01", y, 1'b1);
        req = 2'b00;
        nxt();
        d = 2'b11; #1;
        check("y_idle_d11", y, 1'b0);
        nxt();

        // Randomized traffic; the per-cycle compare checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            en    = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
            done  = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
            d     = 2'($urandom_range(0, 3));
            nxt();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
